clip_memory_port: RTL
=====================

// Module: clip_memory_port
// PURPOSE
//  Responder for the controller's memory_N_enable / memory_N_rw command pair; one instance per clip.
//  Record: accepts samples from the deserializer over valid/ready and stores them sequentially in internal RAM.
//  Play: streams the stored clip to the serializer over valid/ready.
//  Reports busy, done, full and clip length back to the controller.
// PARAMETERS
//  DATA_W   16    sample width in bits
//  DEPTH    4096  clip capacity in samples; ADDR_W = $clog2(DEPTH)
// PORTS
//  clock_i      in   1         100 MHz system clock; the only clock
//  reset_i      in   1         asynchronous, active-low reset
//  enable_i     in   1         command active (from controller memory_N_enable_o)
//  rw_i         in   1         1 = record (write), 0 = play (read); sampled only on command start
//  wr_data_i    in   DATA_W    sample from the deserializer
//  wr_valid_i   in   1         wr_data_i valid
//  wr_ready_o   out  1         port accepts wr_data_i
//  rd_data_o    out  DATA_W    sample to the serializer
//  rd_valid_o   out  1         rd_data_o valid
//  rd_ready_i   in   1         serializer accepts rd_data_o
//  busy_o       out  1         recording or playing in progress
//  done_o       out  1         one-cycle pulse: command finished
//  full_o       out  1         clip holds DEPTH samples
//  clip_len_o   out  ADDR_W+1  stored sample count, 0..DEPTH
// BEHAVIOUR
//  Reset (reset_i=0, async):
//   - state IDLE; every output 0; addr=0; clip_len=0.
//   - RAM contents are not cleared, but the clip is treated as empty.
//  Memory: single-port synchronous RAM, 1-cycle read latency.
//  FSM states: IDLE, WRITE, RD_FETCH, RD_PRESENT, DONE, RELEASE.
//  IDLE, enable_i=1:
//   - rw_i=1 -> WRITE; addr, clip_len and full_o cleared.
//   - rw_i=0 and clip_len=0 -> DONE.
//   - rw_i=0 and clip_len>0 -> RD_FETCH with addr=0.
//  WRITE:
//   - wr_ready_o = enable_i & ~full_o (combinational).
//   - On wr_valid_i & wr_ready_o: mem[addr]<=wr_data_i, addr++ and clip_len++.
//   - Transfer that makes clip_len=DEPTH: full_o<=1, next state DONE.
//   - enable_i=0 -> DONE; no transfer is taken in that cycle.
//  RD_FETCH: issue read of mem[addr]; rd_valid_o=0; always -> RD_PRESENT. enable_i=0 -> DONE instead.
//  RD_PRESENT:
//   - rd_valid_o=1; rd_data_o registered and stable until rd_ready_i.
//   - Handshake, addr<clip_len-1 -> addr++, RD_FETCH.
//   - Handshake, last word -> DONE.
//   - Throughput is therefore one sample per 2 cycles minimum.
//   - enable_i=0 -> DONE; a handshake in that same cycle still counts.
//  DONE: done_o=1 for exactly one cycle; busy_o=0; -> RELEASE.
//  RELEASE: wait for enable_i=0, then -> IDLE. A held enable never retriggers.
//  busy_o = state in {WRITE, RD_FETCH, RD_PRESENT}, registered with state.
//  rw_i changes mid-command are ignored.
//  Reset mid-command aborts the command: outputs 0, clip_len 0.
//  clip_len_o holds its value through playback and changes only during record or on reset.
// CONFIGURATION
//  LOOP_PLAYBACK_EN defined:
//   - Handshake of the last word -> addr=0, RD_FETCH.
//   - Play continues until enable_i=0, then DONE.
//  LOOP_PLAYBACK_EN undefined: playback ends after the last word as described above.
// TESTING (DEPTH=8 for the bench)
//  1. Reset, then enable=1, rw=0 on an empty clip -> done_o pulse 1 cycle later, rd_valid_o never 1, busy_o stays 0.
//  2. Record 0x0001..0x0005 with wr_valid=1, then enable=0 -> clip_len_o=5, full_o=0, one done_o pulse.
//  3. Play with rd_ready=1 -> rd_data 1,2,3,4,5; each valid 1 cycle with a 1-cycle gap; done_o after the 5th.
//  4. Record 9 samples, valid held -> 8 written, full_o=1, wr_ready_o=0, done; later playback shows 9th sample absent.
//  5. rd_ready=0 for 10 cycles in RD_PRESENT -> rd_valid_o=1 and rd_data_o constant; then release -> next sample.
//  6. Reset pulse after 3 recorded samples -> all outputs 0, clip_len_o=0.
//     With LOOP_PLAYBACK_EN and a 3-sample clip -> 1,2,3,1,2,... until enable=0, then done_o.

Source files
------------

// File: rtl/clip_memory_port.sv
// clip_memory_port: records one audio clip into a private RAM and plays it back,
// answering the controller's enable/rw command pair over valid/ready streams.
//
// Ports:
//   clock_i     in   1         system clock
//   reset_i     in   1         asynchronous active-low reset
//   enable_i    in   1         command active
//   rw_i        in   1         1 = record, 0 = play (taken at command start)
//   wr_data_i   in   DATA_W    sample from the deserializer
//   wr_valid_i  in   1         wr_data_i valid
//   wr_ready_o  out  1         port accepts wr_data_i
//   rd_data_o   out  DATA_W    sample to the serializer
//   rd_valid_o  out  1         rd_data_o valid
//   rd_ready_i  in   1         serializer accepts rd_data_o
//   busy_o      out  1         record or play in progress
//   done_o      out  1         one-cycle pulse when a command finishes
//   full_o      out  1         clip holds DEPTH samples
//   clip_len_o  out  ADDR_W+1  stored sample count
//
// Build option: define LOOP_PLAYBACK_EN to make playback wrap to the first
// sample after the last one, running until enable_i drops.

module clip_memory_port #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              rw_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              full_o,
  output logic [ADDR_W:0]   clip_len_o
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_FETCH,
    RD_PRESENT,
    DONE,
    RELEASE
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [ADDR_W:0]     r_clip_len;
  logic [ADDR_W:0]     w_len_next;
  logic                r_full;
  logic                w_full_next;

  logic                r_busy;
  logic                r_done;
  logic                r_valid;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_wr_ready;
  logic                w_wr_fire;
  logic                w_last;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign w_wr_ready = (r_state == WRITE)
                    & enable_i
                    & ~r_full;

  assign w_last = ({1'b0, r_addr}
                   == (r_clip_len - 1'b1));

  always_comb begin
    w_next      = r_state;
    w_addr_next = r_addr;
    w_len_next  = r_clip_len;
    w_full_next = r_full;
    w_wr_fire   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable_i) begin
          if (rw_i) begin
            w_next      = WRITE;
            w_addr_next = '0;
            w_len_next  = '0;
            w_full_next = 1'b0;
          end else if (r_clip_len == '0) begin
            w_next = DONE;
          end else begin
            w_next      = RD_FETCH;
            w_addr_next = '0;
          end
        end
      end
      WRITE: begin
        if (!enable_i) begin
          w_next = DONE;
        end else if (wr_valid_i && w_wr_ready) begin
          w_wr_fire   = 1'b1;
          w_addr_next = r_addr + 1'b1;
          w_len_next  = r_clip_len + 1'b1;
          if (r_clip_len == LEN_MAX - 1'b1) begin
            w_full_next = 1'b1;
            w_next      = DONE;
          end
        end
      end
      RD_FETCH: begin
        w_next = enable_i ? RD_PRESENT : DONE;
      end
      RD_PRESENT: begin
        // rd_valid_o is high here, so ready alone completes the handshake
        if (rd_ready_i) begin
          if (!w_last) begin
            w_addr_next = r_addr + 1'b1;
            w_next      = RD_FETCH;
          end else begin
`ifdef LOOP_PLAYBACK_EN
            w_addr_next = '0;
            w_next      = RD_FETCH;
`else
            w_next      = DONE;
`endif
          end
        end
        // dropping enable ends play; a same-cycle handshake is still consumed
        if (!enable_i) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = RELEASE;
      end
      RELEASE: begin
        if (!enable_i) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_clip_len <= '0;
      r_full     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_addr     <= w_addr_next;
      r_clip_len <= w_len_next;
      r_full     <= w_full_next;
      r_busy     <= (w_next == WRITE)
                 || (w_next == RD_FETCH)
                 || (w_next == RD_PRESENT);
      r_done     <= (w_next == DONE);
      r_valid    <= (w_next == RD_PRESENT);
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_wr_fire) begin
      mem[r_addr] <= wr_data_i;
    end
  end

  // read register only loads in RD_FETCH, so data holds through a stall
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rd_data <= '0;
    end else if (r_state == RD_FETCH) begin
      r_rd_data <= mem[r_addr];
    end
  end

  assign wr_ready_o = w_wr_ready;
  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_valid;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign full_o     = r_full;
  assign clip_len_o = r_clip_len;

endmodule
